// File: rtl/rv32_data_mem_responder.sv
// Data-side memory responder for the RV32 core: word RAM plus a small MMIO window
// (CYCLE, SCRATCH, GPIO), fixed 1-cycle load latency, sticky access-error flags.
module rv32_data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
  parameter int unsigned GPIO_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           mem_address,
  input  logic [31:0]           mem_write_data,
  input  logic                  mem_write_en,
  input  logic                  mem_read_en,
  output logic [31:0]           mem_read_data,
  output logic                  mem_read_valid,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  err_misaligned,
  output logic                  err_unmapped,
  input  logic                  err_clear
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  // Address decode
  logic [31:0]   ram_off;
  logic [31:0]   mmio_off;
  logic          misaligned;
  logic          ram_hit;
  logic          mmio_hit;
  logic          unmapped;
  logic          access;
  logic [AW-1:0] ram_idx;

  always_comb begin
    ram_off    = mem_address - RAM_BASE;
    mmio_off   = mem_address - MMIO_BASE;
    misaligned = (mem_address[1:0] != 2'b00);
    ram_hit    = !misaligned && ({1'b0, ram_off} < RAM_BYTES);
    mmio_hit   = !misaligned && !ram_hit && (mmio_off < 32'd12);
    unmapped   = !misaligned && !ram_hit && !mmio_hit;
    access     = mem_read_en | mem_write_en;
    ram_idx    = ram_off[AW+1:2];
  end

  // Registered state
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] gpio_q, gpio_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_src_ram_q, rd_src_ram_d;
  logic        valid_q, valid_d;
  logic        err_mis_q, err_mis_d;
  logic        err_unm_q, err_unm_d;
  logic [31:0] mmio_rdata;

  always_comb begin
    cycle_d   = cycle_q + 32'd1;
    scratch_d = scratch_q;
    gpio_d    = gpio_q;
    if (mem_write_en && mmio_hit) begin
      if (mmio_off[3:2] == 2'd1) scratch_d = mem_write_data;
      if (mmio_off[3:2] == 2'd2) gpio_d    = mem_write_data;
    end

    // Zero for misaligned/unmapped loads; RAM data comes from the RAM read register.
    mmio_rdata = 32'h0;
    if (mmio_hit) begin
      case (mmio_off[3:2])
        2'd0:    mmio_rdata = cycle_q;
        2'd1:    mmio_rdata = scratch_q;
        2'd2:    mmio_rdata = gpio_q;
        default: mmio_rdata = 32'h0;
      endcase
    end

    rd_data_d    = rd_data_q;
    rd_src_ram_d = rd_src_ram_q;
    if (mem_read_en) begin
      rd_src_ram_d = ram_hit;
      rd_data_d    = mmio_rdata;
    end
    valid_d = mem_read_en;

    // A new error in the same cycle as a clear takes precedence.
    err_mis_d = (access && misaligned) ? 1'b1 : (err_clear ? 1'b0 : err_mis_q);
    err_unm_d = (access && unmapped)   ? 1'b1 : (err_clear ? 1'b0 : err_unm_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q      <= 32'h0;
      scratch_q    <= 32'h0;
      gpio_q       <= 32'h0;
      rd_data_q    <= 32'h0;
      rd_src_ram_q <= 1'b0;
      valid_q      <= 1'b0;
      err_mis_q    <= 1'b0;
      err_unm_q    <= 1'b0;
    end else begin
      cycle_q      <= cycle_d;
      scratch_q    <= scratch_d;
      gpio_q       <= gpio_d;
      rd_data_q    <= rd_data_d;
      rd_src_ram_q <= rd_src_ram_d;
      valid_q      <= valid_d;
      err_mis_q    <= err_mis_d;
      err_unm_q    <= err_unm_d;
    end
  end

  // Data RAM: read-first, registered read, contents not reset
  logic [31:0] ram_q [DEPTH_WORDS];
  logic [31:0] ram_rdata_q;

  always_ff @(posedge clk) begin
    if (rst_n && mem_write_en && ram_hit) ram_q[ram_idx] <= mem_write_data;
    if (mem_read_en && ram_hit)           ram_rdata_q    <= ram_q[ram_idx];
  end

  assign mem_read_data  = rd_src_ram_q ? ram_rdata_q : rd_data_q;
  assign mem_read_valid = valid_q;
  assign gpio_out       = gpio_q[GPIO_WIDTH-1:0];
  assign err_misaligned = err_mis_q;
  assign err_unmapped   = err_unm_q;

endmodule

// File: tb/tb_rv32_data_mem_responder.sv
// Scoreboard bench for rv32_data_mem_responder: directed accesses push expected load
// responses; a negedge monitor pops and checks data and 1-cycle latency.
module tb_rv32_data_mem_responder;

  localparam logic [31:0] MMIO   = 32'h1000_0000;
  localparam logic [31:0] A_CYC  = MMIO + 32'h0;
  localparam logic [31:0] A_SCR  = MMIO + 32'h4;
  localparam logic [31:0] A_GPIO = MMIO + 32'h8;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_read_data;
  logic        mem_read_valid;
  logic [7:0]  gpio_out;
  logic        err_misaligned;
  logic        err_unmapped;
  logic        err_clear;

  rv32_data_mem_responder #(
    .DEPTH_WORDS(1024),
    .RAM_BASE   (32'h0000_0000),
    .MMIO_BASE  (MMIO),
    .GPIO_WIDTH (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_write_en  (mem_write_en),
    .mem_read_en   (mem_read_en),
    .mem_read_data (mem_read_data),
    .mem_read_valid(mem_read_valid),
    .gpio_out      (gpio_out),
    .err_misaligned(err_misaligned),
    .err_unmapped  (err_unmapped),
    .err_clear     (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned tick = 0;
  int unsigned ref_cycle = 0;

  // tick never resets (latency reference); ref_cycle is the expected CYCLE value.
  always @(posedge clk) begin
    tick      <= tick + 1;
    ref_cycle <= rst_n ? ref_cycle + 1 : 0;
  end

  typedef struct {
    logic [31:0] data;
    int unsigned t;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t head;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].t + 1 < tick) begin
      head = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: no response at tick %0d, required data %h", head.name, head.t + 1, head.data);
    end
    if (mem_read_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got data %h at tick %0d, required no response", mem_read_data, tick);
      end else begin
        head = exp_q.pop_front();
        if (mem_read_data !== head.data || head.t + 1 != tick) begin
          errors++;
          $display("FAIL %s: got %h at tick %0d, required %h at tick %0d",
                   head.name, mem_read_data, tick, head.data, head.t + 1);
        end else begin
          $display("load %-14s data %h", head.name, mem_read_data);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // One access cycle; inputs change 1 time unit after the rising edge.
  task automatic access(input logic re, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic clr,
                        input logic [31:0] exp_data, input string nm);
    exp_t e;
    mem_read_en    = re;
    mem_write_en   = we;
    mem_address    = a;
    mem_write_data = wd;
    err_clear      = clr;
    if (re) begin
      e.data = exp_data;
      e.t    = tick;
      e.name = nm;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    err_clear    = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] wd);
    access(1'b0, 1'b1, a, wd, 1'b0, 32'h0, "");
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] exp_data, input string nm);
    access(1'b1, 1'b0, a, 32'h0, 1'b0, exp_data, nm);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] c0;
    rst_n = 1'b0; mem_address = 32'h0; mem_write_data = 32'h0;
    mem_write_en = 1'b0; mem_read_en = 1'b0; err_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values, then CYCLE load in the first post-reset cycle
    check("rst_data", mem_read_data, 32'h0);
    check("rst_valid", {31'h0, mem_read_valid}, 32'h0);
    check("rst_gpio", {24'h0, gpio_out}, 32'h0);
    check("rst_err_mis", {31'h0, err_misaligned}, 32'h0);
    check("rst_err_unm", {31'h0, err_unmapped}, 32'h0);
    load(A_CYC, 32'h0, "cycle_first");

    // Back-to-back RAM traffic
    store(32'h10, 32'hA5A5_0001);
    load(32'h10, 32'hA5A5_0001, "ram_0x10");
    store(32'hFFC, 32'hDEAD_BEEF);
    load(32'hFFC, 32'hDEAD_BEEF, "ram_last");
    store(32'h0, 32'h0BAD_F00D);
    load(32'h10, 32'hA5A5_0001, "ram_b2b_a");
    load(32'hFFC, 32'hDEAD_BEEF, "ram_b2b_b");

    // Same-cycle read/write is read-first
    store(32'h20, 32'h1111_1111);
    access(1'b1, 1'b1, 32'h20, 32'h2222_2222, 1'b0, 32'h1111_1111, "rw_old");
    load(32'h20, 32'h2222_2222, "rw_new");

    // MMIO
    store(A_GPIO, 32'h0000_01FF);
    check("gpio_out", {24'h0, gpio_out}, 32'h0000_00FF);
    load(A_GPIO, 32'h0000_01FF, "gpio_read");
    store(A_SCR, 32'hCAFE_F00D);
    load(A_SCR, 32'hCAFE_F00D, "scratch");
    store(A_CYC, 32'h1234_5678);
    check("cyc_wr_err_mis", {31'h0, err_misaligned}, 32'h0);
    check("cyc_wr_err_unm", {31'h0, err_unmapped}, 32'h0);
    load(A_CYC, ref_cycle, "cycle_after_wr");
    c0 = ref_cycle;
    load(A_CYC, c0, "cycle_t0");
    idle(4);
    load(A_CYC, c0 + 32'd5, "cycle_t0_plus5");

    // Errors
    load(32'h13, 32'h0, "misaligned_ld");
    check("mis_flag", {31'h0, err_misaligned}, 32'h1);
    check("mis_no_unm", {31'h0, err_unmapped}, 32'h0);
    store(32'h2000_0000, 32'h5555_5555);
    check("unm_flag", {31'h0, err_unmapped}, 32'h1);
    load(32'h0, 32'h0BAD_F00D, "unm_no_write");
    load(MMIO + 32'hC, 32'h0, "mmio_end_unm");
    access(1'b0, 1'b1, 32'h22, 32'h7777_7777, 1'b1, 32'h0, "");
    check("clr_set_mis", {31'h0, err_misaligned}, 32'h1);
    check("clr_unm", {31'h0, err_unmapped}, 32'h0);
    load(32'h20, 32'h2222_2222, "mis_no_write");
    access(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, "");
    check("clr_mis", {31'h0, err_misaligned}, 32'h0);
    check("clr_unm2", {31'h0, err_unmapped}, 32'h0);

    // Reset during an access cancels it
    store(32'h30, 32'h3030_3030);
    rst_n = 1'b0;
    mem_read_en = 1'b1; mem_write_en = 1'b1;
    mem_address = 32'h30; mem_write_data = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    mem_read_en = 1'b0; mem_write_en = 1'b0; rst_n = 1'b1;
    check("rstmid_valid", {31'h0, mem_read_valid}, 32'h0);
    check("rstmid_data", mem_read_data, 32'h0);
    check("rstmid_gpio", {24'h0, gpio_out}, 32'h0);
    load(32'h30, 32'h3030_3030, "rstmid_ram");
    load(A_SCR, 32'h0, "rstmid_scratch");
    load(A_GPIO, 32'h0, "rstmid_gpio_rd");
    load(A_CYC, 32'd3, "rstmid_cycle");

    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d outstanding responses required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
